// File: rtl/kbd_xt_pkg.sv
// Shared constants for the XT keyboard interface: I/O port numbers,
// PS/2 receiver state encodings and the frame-check helper.
package kbd_xt_pkg;

    localparam logic [11:0] KBD_DATA = 12'h060;
    localparam logic [11:0] KBD_CTRL = 12'h061;

    localparam logic [1:0] RX_IDLE   = 2'd0;
    localparam logic [1:0] RX_DATA   = 2'd1;
    localparam logic [1:0] RX_PARITY = 2'd2;
    localparam logic [1:0] RX_STOP   = 2'd3;

    // A PS/2 frame is good when the stop bit is 1 and data+parity carry odd parity.
    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return stop & (^{data, par});
    endfunction

endpackage

// File: rtl/kbd_xt_ps2_rx.sv
// PS/2 device-to-host receiver: synchronisers, glitch filters, frame FSM
// and frame timeout. Emits each good byte with a one-cycle valid strobe.
module ps2_rx
    import kbd_xt_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 25_000_000,
    parameter int unsigned FILT       = 8,
    parameter int unsigned TIMEOUT_US = 2000
) (
    input  logic       iClk,
    input  logic       iRstN,
    input  logic       iPs2Clk,
    input  logic       iPs2Dat,
    output logic [7:0] oByte,
    output logic       oValid
);

    localparam int unsigned TMO_CYC = (CLK_HZ / 1_000_000) * TIMEOUT_US;
    localparam int unsigned TW      = $clog2(TMO_CYC + 1);
    localparam int unsigned FW      = $clog2(FILT + 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic [FW-1:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
    logic          clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
    logic          clk_prev_q;
    logic          fall;

    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;

    // Filtered level only follows the synchronised input after FILT
    // consecutive samples that disagree with it.
    always_comb begin
        clk_filt_d = clk_filt_q;
        clk_cnt_d  = '0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (clk_cnt_q == FW'(FILT - 1)) begin
                clk_filt_d = clk_sync_q[1];
            end else begin
                clk_cnt_d = clk_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        dat_filt_d = dat_filt_q;
        dat_cnt_d  = '0;
        if (dat_sync_q[1] != dat_filt_q) begin
            if (dat_cnt_q == FW'(FILT - 1)) begin
                dat_filt_d = dat_sync_q[1];
            end else begin
                dat_cnt_d = dat_cnt_q + 1'b1;
            end
        end
    end

    assign fall = clk_prev_q & ~clk_filt_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        oValid  = 1'b0;
        tmo_d   = (state_q == RX_IDLE) ? '0 : tmo_q + 1'b1;

        // Timeout takes priority over a coincident sample event.
        if (state_q != RX_IDLE && tmo_q == TW'(TMO_CYC)) begin
            state_d = RX_IDLE;
            tmo_d   = '0;
        end else if (fall) begin
            tmo_d = '0;
            case (state_q)
                RX_IDLE: begin
                    if (!dat_filt_q) begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                    end
                end
                RX_DATA: begin
                    shift_d = {dat_filt_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    par_d   = dat_filt_q;
                    state_d = RX_STOP;
                end
                default: begin
                    oValid  = frame_ok(shift_q, par_q, dat_filt_q);
                    state_d = RX_IDLE;
                end
            endcase
        end
    end

    assign oByte = shift_q;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_cnt_q  <= '0;
            dat_cnt_q  <= '0;
            clk_filt_q <= 1'b1;
            dat_filt_q <= 1'b1;
            clk_prev_q <= 1'b1;
            state_q    <= RX_IDLE;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], iPs2Clk};
            dat_sync_q <= {dat_sync_q[0], iPs2Dat};
            clk_cnt_q  <= clk_cnt_d;
            dat_cnt_q  <= dat_cnt_d;
            clk_filt_q <= clk_filt_d;
            dat_filt_q <= dat_filt_d;
            clk_prev_q <= clk_filt_q;
            state_q    <= state_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
        end
    end

endmodule

// File: rtl/kbd_xt.sv
// XT keyboard interface: PS/2 receiver, byte FIFO, port 60h scan-code latch
// driving IRQ1, and port 61h bit-7 acknowledge.
module kbd_xt
    import kbd_xt_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 25_000_000,
    parameter int unsigned FILT       = 8,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter int unsigned DEPTH      = 8
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iPs2Clk,
    input  logic        iPs2Dat,
    input  logic [19:0] iAddr,
    input  logic [7:0]  iWrData,
    input  logic        iWr,
    input  logic        iRd,
    output logic        oIrq1,
    output logic        oSel,
    output logic [7:0]  oData
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [1:0]  rst_sync_q;
    logic        rst_n;

    logic [7:0]  rx_byte;
    logic        rx_valid;

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty, fifo_full, push, pop;

    logic [7:0]  latch_q, latch_d;
    logic        full_q, full_d;
    logic        sel_q, sel_d;
    logic [7:0]  data_q, data_d;
    logic        ack, rd_data;
    logic        unused;

    // Assert asynchronously, release two edges later so every flop leaves reset together.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    ps2_rx #(
        .CLK_HZ     (CLK_HZ),
        .FILT       (FILT),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_rx (
        .iClk    (iClk),
        .iRstN   (rst_n),
        .iPs2Clk (iPs2Clk),
        .iPs2Dat (iPs2Dat),
        .oByte   (rx_byte),
        .oValid  (rx_valid)
    );

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_data = iRd & (iAddr[11:0] == KBD_DATA);
    assign ack     = iWr & (iAddr[11:0] == KBD_CTRL) & iWrData[7];
    assign unused  = ^{iAddr[19:12], iWrData[6:0]};

    assign push = rx_valid & ~fifo_full;
    // An acknowledge blocks a same-cycle load so IRQ1 drops for at least one cycle.
    assign pop  = ~full_q & ~fifo_empty & ~ack;

    always_comb begin
        full_d  = full_q;
        latch_d = latch_q;
        if (ack) begin
            full_d = 1'b0;
        end else if (pop) begin
            full_d  = 1'b1;
            latch_d = mem_q[rd_ptr_q[AW-1:0]];
        end
        sel_d  = rd_data;
        data_d = rd_data ? latch_q : '0;
    end

    always_ff @(posedge iClk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge iClk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            latch_q  <= '0;
            full_q   <= 1'b0;
            sel_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            latch_q <= latch_d;
            full_q  <= full_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign oIrq1 = full_q;
    assign oSel  = sel_q;
    assign oData = data_q;

endmodule

// File: tb/tb_kbd_xt.sv
// Directed + randomized bench for kbd_xt: PS/2 frames are driven at ~12 kHz
// and delivered bytes are checked against a queue model of latch+FIFO.
`timescale 1ns/1ps
module tb_kbd_xt;

    localparam int unsigned CLK_HZ     = 1_000_000;
    localparam int unsigned FILT       = 8;
    localparam int unsigned TIMEOUT_US = 2000;
    localparam int unsigned DEPTH      = 8;
    localparam int          HALF       = 42;   // PS/2 half period in 1 us cycles

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2c = 1'b1, ps2d = 1'b1;
    logic [19:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        wr = 1'b0, rd = 1'b0;
    logic        irq, sel;
    logic [7:0]  data;

    int checks = 0;
    int fails  = 0;
    int cyc = 0;
    int rise_cnt = 0, rise_cyc = 0, fall_cyc = 0;
    logic irq_prev = 1'b0;
    byte unsigned exp_q[$];

    kbd_xt #(
        .CLK_HZ     (CLK_HZ),
        .FILT       (FILT),
        .TIMEOUT_US (TIMEOUT_US),
        .DEPTH      (DEPTH)
    ) dut (
        .iClk    (clk),
        .iRstN   (rst_n),
        .iPs2Clk (ps2c),
        .iPs2Dat (ps2d),
        .iAddr   (addr),
        .iWrData (wdata),
        .iWr     (wr),
        .iRd     (rd),
        .oIrq1   (irq),
        .oSel    (sel),
        .oData   (data)
    );

    always #500 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (irq === 1'b1 && irq_prev === 1'b0) begin
            rise_cnt = rise_cnt + 1;
            rise_cyc = cyc;
        end
        irq_prev = irq;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: with no acknowledges in flight, latch plus FIFO hold 1+DEPTH good bytes.
    function automatic void model_push(input byte unsigned b, input bit good);
        if (good && exp_q.size() < 1 + DEPTH) exp_q.push_back(b);
    endfunction

    task automatic ps2_bit(input logic b, input bit mark);
        @(negedge clk);
        ps2d = b;
        repeat (HALF / 2) @(negedge clk);
        ps2c = 1'b0;
        if (mark) fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2c = 1'b1;
        repeat (HALF / 2) @(negedge clk);
    endtask

    task automatic send_frame(input byte unsigned b, input bit bad_par, input bit bad_stop);
        logic p;
        p = (~^b) ^ bad_par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(p, 1'b0);
        ps2_bit(~bad_stop, 1'b1);
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_irq(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (irq !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, irq}, {31'd0, lvl});
    endtask

    task automatic rd_port(input logic [19:0] a, output logic s, output logic [7:0] d);
        @(negedge clk);
        addr = a;
        rd   = 1'b1;
        @(negedge clk);
        rd   = 1'b0;
        addr = '0;
        s = sel;
        d = data;
    endtask

    task automatic wr_port(input logic [19:0] a, input logic [7:0] v);
        @(negedge clk);
        addr  = a;
        wdata = v;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
        wdata = '0;
        addr  = '0;
    endtask

    task automatic expect_byte(input byte unsigned b, input string tag);
        logic s;
        logic [7:0] d;
        wait_irq(1'b1, 3000, {tag, "_irq"});
        rd_port(20'hA5060, s, d);
        chk({tag, "_sel"}, {31'd0, s}, 32'd1);
        chk({tag, "_data"}, {24'd0, d}, {24'd0, b});
        wr_port(20'h00061, 8'h80);
        chk({tag, "_ack_low"}, {31'd0, irq}, 32'd0);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) expect_byte(exp_q.pop_front(), tag);
        repeat (30) @(negedge clk);
        chk({tag, "_no_stray"}, {31'd0, irq}, 32'd0);
    endtask

    initial begin
        logic s;
        logic [7:0] d;
        byte unsigned b;
        bit err, which;
        int r0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_sel", {31'd0, sel}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte: latency, non-destructive reads, 61h handling
        send_frame(8'h1E, 1'b0, 1'b0);
        chk("single_irq", {31'd0, irq}, 32'd1);
        chk("single_latency_win",
            {31'd0, (rise_cyc - fall_cyc >= int'(FILT) + 3) && (rise_cyc - fall_cyc <= int'(FILT) + 5)}, 32'd1);
        rd_port(20'h00060, s, d);
        chk("single_sel", {31'd0, s}, 32'd1);
        chk("single_data", {24'd0, d}, 32'h1E);
        @(negedge clk);
        chk("single_sel_pulse", {31'd0, sel}, 32'd0);
        rd_port(20'h00061, s, d);
        chk("rd61_unclaimed", {31'd0, s}, 32'd0);
        rd_port(20'h00064, s, d);
        chk("rd_other_unclaimed", {31'd0, s}, 32'd0);
        wr_port(20'h00061, 8'h7F);
        chk("wr61_bit7_0_irq", {31'd0, irq}, 32'd1);
        rd_port(20'h00060, s, d);
        chk("single_reread", {24'd0, d}, 32'h1E);
        wr_port(20'h00061, 8'h80);
        chk("single_ack_low", {31'd0, irq}, 32'd0);
        rd_port(20'h00060, s, d);
        chk("empty_latch_last", {24'd0, d}, 32'h1E);

        // Queued bytes
        send_frame(8'h2A, 1'b0, 1'b0); model_push(8'h2A, 1'b1);
        send_frame(8'h9E, 1'b0, 1'b0); model_push(8'h9E, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b0); model_push(8'hAA, 1'b1);
        drain("queued");

        // Errors: bad parity, bad stop, then a good frame
        r0 = rise_cnt;
        send_frame(8'h11, 1'b1, 1'b0); model_push(8'h11, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1); model_push(8'h22, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0); model_push(8'h1C, 1'b1);
        wait_irq(1'b1, 3000, "err_irq");
        chk("err_one_rise", rise_cnt - r0, 32'd1);
        drain("errors");

        // Timeout: 4 bits then a stall longer than the frame timeout
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        repeat (TIMEOUT_US + 10) @(negedge clk);
        chk("tmo_no_irq", {31'd0, irq}, 32'd0);
        send_frame(8'h39, 1'b0, 1'b0); model_push(8'h39, 1'b1);
        drain("timeout");

        // Overflow with random bytes, latch unacknowledged
        for (int i = 0; i < int'(DEPTH) + 3; i++) begin
            b = byte'($urandom_range(0, 255));
            send_frame(b, 1'b0, 1'b0);
            model_push(b, 1'b1);
        end
        chk("ovf_model_len", exp_q.size(), 1 + DEPTH);
        drain("overflow");

        // Random frames with random corruption
        for (int i = 0; i < 6; i++) begin
            b     = byte'($urandom_range(0, 255));
            err   = ($urandom_range(0, 3) == 0);
            which = $urandom_range(0, 1) == 1;
            send_frame(b, err & which, err & ~which);
            model_push(b, !err);
        end
        drain("random");

        // Glitch on the PS/2 clock while data looks like a start bit
        @(negedge clk);
        ps2d = 1'b0;
        repeat (20) @(negedge clk);
        ps2c = 1'b0;
        repeat (FILT - 2) @(negedge clk);
        ps2c = 1'b1;
        repeat (20) @(negedge clk);
        ps2d = 1'b1;
        repeat (30) @(negedge clk);
        send_frame(8'h55, 1'b0, 1'b0); model_push(8'h55, 1'b1);
        drain("glitch");

        // Mid-frame reset with IRQ1, oSel and oData all active
        send_frame(8'h5A, 1'b0, 1'b0);
        wait_irq(1'b1, 3000, "mrst_irq");
        @(negedge clk);
        addr = 20'h00060;
        rd   = 1'b1;
        @(negedge clk);
        chk("mrst_sel_pre", {31'd0, sel}, 32'd1);
        chk("mrst_data_pre", {24'd0, data}, 32'h5A);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2d = 1'b0;
        ps2c = 1'b0;
        repeat (5) @(negedge clk);
        #200 rst_n = 1'b0;
        #1;
        chk("mrst_irq", {31'd0, irq}, 32'd0);
        chk("mrst_sel", {31'd0, sel}, 32'd0);
        chk("mrst_data", {24'd0, data}, 32'd0);
        @(negedge clk);
        rd   = 1'b0;
        addr = '0;
        ps2c = 1'b1;
        ps2d = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("mrst_after_irq", {31'd0, irq}, 32'd0);
        send_frame(8'h6B, 1'b0, 1'b0); model_push(8'h6B, 1'b1);
        drain("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/kbd_xt.md
# kbd_xt

XT-style keyboard interface that sits directly upstream of the interrupt controller and drives its IRQ1 input. Receives PS/2 device-to-host frames, buffers completed bytes in a small FIFO and presents one byte at a time in the port 60h scan-code latch. The latch drives IRQ1 until the BIOS acknowledges through port 61h bit 7. Bytes are delivered unmodified; no scan-code-set translation is performed.

## Interface
- CLK_HZ, 25_000_000, system clock frequency; used to size the frame timeout.
- FILT, 8, glitch-filter length in cycles for PS/2 clock and data.
- TIMEOUT_US, 2000, maximum frame duration in microseconds before a partial frame is abandoned.
- DEPTH, 8, receive FIFO depth; must be a power of two and at least 2.
- iClk  in  1  system clock.
- iRstN  in  1  asynchronous, active-low reset.
- iPs2Clk  in  1  PS/2 clock, asynchronous; host never drives it.
- iPs2Dat  in  1  PS/2 data, asynchronous.
- iAddr  in  20  I/O address; decoded on bits [11:0].
- iWrData  in  8  I/O write data.
- iWr  in  1  single-cycle I/O write strobe.
- iRd  in  1  single-cycle I/O read strobe.
- oIrq1  out  1  level interrupt request to the PIC IRQ1 input.
- oSel  out  1  one-cycle pulse marking oData valid for a read.
- oData  out  8  read data.

## Operation
- **Input conditioning.** iPs2Clk and iPs2Dat each pass through a 2-flop synchroniser and then a filter. A filtered value changes only after FILT consecutive identical samples. A falling edge of the filtered clock is a sample event.
- **Receiver FSM.** States are IDLE, DATA, PARITY and STOP.
  - IDLE: on a sample event with data 0 (start bit), go to DATA with the bit count at 0. A sample event with data 1 is ignored.
  - DATA: shift in 8 bits LSB first, then go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: the frame is good when the stop bit is 1 and the 9 data+parity bits have odd parity. A good frame pushes its byte into the FIFO. Any other frame is discarded silently. The FSM always returns to IDLE.
- **Frame timeout.** A cycle counter runs while the FSM is outside IDLE and clears on every sample event. When it reaches CLK_HZ/1e6*TIMEOUT_US, the FSM returns to IDLE and the partial byte is discarded.
- **FIFO.** The FIFO has DEPTH entries, with pointers one bit wider than the index.
  - If the FIFO is full, a push drops the incoming byte and leaves FIFO contents unchanged.
  - A push and a pop in the same cycle are both honoured.
- **Latch.**
  - When the latch is empty and the FIFO is not empty, pop one byte into the latch and set the full flag.
  - oIrq1 equals the full flag.
- **Port 60h read.** Sets oSel=1 and oData=latch on the next cycle. The read does not clear the latch. If the latch is empty, the read returns the last byte that was latched.
- **Port 61h write with iWrData[7]=1.** Clears the full flag; oIrq1 goes low.
- **Other port 61h accesses.** A write with bit 7=0 has no effect here. Reads of 61h are not claimed (oSel stays 0), because port 61h is owned by the system-control block.
- **Other addresses.** oSel=0.

## Timing
- **Reset values.** oIrq1=0, oSel=0, oData=0, full flag 0, FIFO empty, FSM IDLE, filtered clock and data at 1, timeout counter at 0.
- **Asynchronous reset.** Assertion takes effect immediately. Deassertion is synchronised internally before the first active edge.
- **Byte latency.** Take cycle N as the cycle in which the stop-bit sample event is detected. The FIFO write happens at N+1. At N+2 the latch is loaded and oIrq1=1, provided the latch was empty.
- **Acknowledge collision.** If an acknowledge and a latch load fall on the same cycle, the acknowledge wins. The load happens on the following cycle, so oIrq1 is low for at least 1 cycle and the PIC edge detector sees a fresh rising edge.
- **Read collision.** A 60h read in the same cycle as a load returns the old latch value.
- **oSel.** Never high for two consecutive cycles unless iRd is held high for two cycles.

## Structure
- Shared package or include holds:
  - port constants KBD_DATA=12'h060 and KBD_CTRL=12'h061;
  - receiver state encodings.
- Sub-module ps2_rx contains the synchronisers, filter, FSM and timeout, and outputs a byte plus a one-cycle valid strobe. The FIFO, latch and bus decode stay in kbd_xt.

## Test plan
- **Single byte.** Frame 0x1E with correct odd parity, PS/2 clock at 12 kHz → oIrq1 rises 2 cycles after the stop sample. A read of 60h gives oSel=1 and oData=0x1E. oIrq1 stays 1 until a write of 0x80 to 61h, then drops to 0.
- **Queued bytes.** Three frames 0x2A, 0x9E, 0xAA with no acknowledge → first latch holds 0x2A. After each 61h=0x80 write, oIrq1 is low for at least 1 cycle and then high, with reads returning 0x9E and then 0xAA.
- **Errors.** A frame with bad parity, then a frame with stop bit 0, then 0x1C → only 0x1C is latched and exactly one IRQ1 rising edge occurs.
- **Timeout.** Send 4 bits and stall for TIMEOUT_US+10 µs, then send a full 0x39 frame → latch holds 0x39 and no stray byte is delivered.
- **Overflow.** Send DEPTH+3 bytes while the latch is unacknowledged → after repeated acknowledges, exactly 1+DEPTH bytes are delivered in order and the last 2 are lost.
- **Mid-frame reset and glitch.** Assert iRstN low mid-frame → all outputs go to 0 immediately, and a frame after release is received correctly. A glitch on iPs2Clk shorter than FILT cycles causes no sample event.
